// File: rtl/z80fi_sched_pkg.sv
// Shared types and widths for the Z80FI check scheduler and its trace filters.
package z80fi_sched_pkg;

  localparam int SCHED_CNT_W = 16;
  localparam int INSN_W      = 32;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/z80fi_insn_match.sv
// Masked opcode compare: hit when every bit selected by the mask equals the pattern.
module z80fi_insn_match
  import z80fi_sched_pkg::*;
(
  input  logic [INSN_W-1:0] i_insn,
  input  logic [INSN_W-1:0] i_match,
  input  logic [INSN_W-1:0] i_mask,
  output logic              o_hit
);

  // An all-zero mask selects no bits, so every instruction is a hit.
  assign o_hit = ((i_insn ^ i_match) & i_mask) == '0;

endmodule

// File: rtl/z80fi_check_sched.sv
// Schedules one instruction check on the Z80FI retirement trace: holds the core
// in reset, then pulses check on the first eligible matching retirement.
module z80fi_check_sched
  import z80fi_sched_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned CHECK_INSN   = 20,
  parameter int unsigned MAX_CYCLES   = 200
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_z80fi_valid,
  input  logic [INSN_W-1:0]      i_z80fi_insn,
  input  logic [INSN_W-1:0]      i_insn_match,
  input  logic [INSN_W-1:0]      i_insn_mask,
  output logic                   o_core_reset,
  output logic                   o_check,
  output logic [SCHED_CNT_W-1:0] o_retire_count,
  output logic                   o_done,
  output logic                   o_timeout
);

  localparam logic [7:0]             HOLD_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [SCHED_CNT_W-1:0] CYC_LAST  = SCHED_CNT_W'(MAX_CYCLES - 1);
  localparam logic [SCHED_CNT_W-1:0] CNT_MAX   = '1;

  sched_state_t           r_state;
  logic [7:0]             r_hold_cnt;
  logic [SCHED_CNT_W-1:0] r_cycle_cnt;
  logic [SCHED_CNT_W-1:0] r_retire_cnt;
  logic                   r_core_reset;
  logic                   r_done;
  logic                   r_timeout;

  logic                   w_hit;
  logic                   w_eligible;
  logic                   w_qualify;
  logic                   w_count;
  logic [SCHED_CNT_W-1:0] w_retire_next;

  z80fi_insn_match u_match (
    .i_insn  (i_z80fi_insn),
    .i_match (i_insn_match),
    .i_mask  (i_insn_mask),
    .o_hit   (w_hit)
  );

  // Eligibility uses the pre-increment count, so retirement N is compared as N.
  assign w_eligible    = 32'(r_retire_cnt) >= CHECK_INSN;
  assign w_qualify     = (r_state == RUN) && i_z80fi_valid && w_eligible && w_hit;
  assign w_count       = i_z80fi_valid && ((r_state == RUN) || (r_state == DONE));
  assign w_retire_next = (r_retire_cnt == CNT_MAX) ? r_retire_cnt : r_retire_cnt + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= HOLD;
      r_hold_cnt   <= '0;
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state      <= RUN;
            r_core_reset <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        RUN: begin
          r_cycle_cnt <= r_cycle_cnt + 1'b1;
          if (w_count) r_retire_cnt <= w_retire_next;
          // A qualifying retirement beats a budget expiry in the same cycle.
          if (w_qualify) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (r_cycle_cnt == CYC_LAST) begin
            r_state   <= TIMEOUT;
            r_timeout <= 1'b1;
          end
        end
        DONE: begin
          if (w_count) r_retire_cnt <= w_retire_next;
        end
        TIMEOUT: begin
          r_state <= TIMEOUT;
        end
        default: r_state <= HOLD;
      endcase
    end
  end

  assign o_check        = w_qualify && !i_reset;
  assign o_core_reset   = r_core_reset;
  assign o_retire_count = r_retire_cnt;
  assign o_done         = r_done;
  assign o_timeout      = r_timeout;

endmodule
